// File: rtl/csr_unit.sv
// Machine-mode CSR file: trap/mret bookkeeping, direct-mode mtvec, and 64-bit
// cycle/instret counters with combinational read and illegal-access decode.
module csr_unit #(
  parameter logic [31:0] HART_ID     = 32'd0,
  parameter logic [31:0] MTVEC_RESET = 32'h0000_0000,
  parameter bit          COUNTER_EN  = 1'b1
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_rd,
  input  logic        i_wr,
  input  logic        i_set,
  input  logic        i_clr,
  input  logic [11:0] i_addr,
  input  logic [31:0] i_wr_data,
  output logic [31:0] o_rd_data,
  output logic        o_illegal,
  input  logic        i_retire,
  input  logic        i_trap,
  input  logic [31:0] i_trap_pc,
  input  logic [31:0] i_trap_cause,
  input  logic [31:0] i_trap_val,
  input  logic        i_mret,
  output logic [31:0] o_trap_vector,
  output logic [31:0] o_epc,
  output logic        o_mie
);

  localparam logic [11:0] A_MSTATUS   = 12'h300;
  localparam logic [11:0] A_MTVEC     = 12'h305;
  localparam logic [11:0] A_MSCRATCH  = 12'h340;
  localparam logic [11:0] A_MEPC      = 12'h341;
  localparam logic [11:0] A_MCAUSE    = 12'h342;
  localparam logic [11:0] A_MTVAL     = 12'h343;
  localparam logic [11:0] A_MCYCLE    = 12'hB00;
  localparam logic [11:0] A_MCYCLEH   = 12'hB80;
  localparam logic [11:0] A_MINSTRET  = 12'hB02;
  localparam logic [11:0] A_MINSTRETH = 12'hB82;
  localparam logic [11:0] A_CYCLE     = 12'hC00;
  localparam logic [11:0] A_CYCLEH    = 12'hC80;
  localparam logic [11:0] A_INSTRET   = 12'hC02;
  localparam logic [11:0] A_INSTRETH  = 12'hC82;
  localparam logic [11:0] A_MHARTID   = 12'hF14;
  localparam logic [31:0] LOW2_MASK   = 32'hFFFF_FFFC;

  logic        mie, mpie;
  logic [31:0] mtvec, mscratch, mepc, mcause, mtval;
  logic [63:0] mcycle, minstret;

  logic [31:0] mstatus_rd, rd_raw, wr_val;
  logic        impl, is_cnt, any_acc, write_op, do_write, sys_wr;

  // MPP is hardwired to machine mode
  assign mstatus_rd = {19'd0, 2'b11, 3'd0, mpie, 3'd0, mie, 3'd0};

  always_comb begin
    rd_raw = 32'd0;
    impl   = 1'b1;
    is_cnt = 1'b0;
    case (i_addr)
      A_MSTATUS:              rd_raw = mstatus_rd;
      A_MTVEC:                rd_raw = mtvec;
      A_MSCRATCH:             rd_raw = mscratch;
      A_MEPC:                 rd_raw = mepc;
      A_MCAUSE:               rd_raw = mcause;
      A_MTVAL:                rd_raw = mtval;
      A_MHARTID:              rd_raw = HART_ID;
      A_MCYCLE, A_CYCLE: begin
        is_cnt = 1'b1;
        rd_raw = mcycle[31:0];
      end
      A_MCYCLEH, A_CYCLEH: begin
        is_cnt = 1'b1;
        rd_raw = mcycle[63:32];
      end
      A_MINSTRET, A_INSTRET: begin
        is_cnt = 1'b1;
        rd_raw = minstret[31:0];
      end
      A_MINSTRETH, A_INSTRETH: begin
        is_cnt = 1'b1;
        rd_raw = minstret[63:32];
      end
      default:                impl = 1'b0;
    endcase
  end

  assign o_rd_data = (is_cnt && !COUNTER_EN) ? 32'd0 : rd_raw;

  assign any_acc  = i_rd | i_wr | i_set | i_clr;
  assign write_op = i_wr | ((i_set | i_clr) & (i_wr_data != 32'd0));
  assign o_illegal = any_acc & (!impl
                              | (write_op & (i_addr[11:10] == 2'b11))
                              | (!COUNTER_EN & is_cnt));

  always_comb begin
    wr_val = o_rd_data & ~i_wr_data;
    if (i_wr)       wr_val = i_wr_data;
    else if (i_set) wr_val = o_rd_data | i_wr_data;
  end

  assign do_write = write_op & ~o_illegal;
  // trap/mret own mstatus/mepc/mcause/mtval in their cycle
  assign sys_wr   = do_write & ~i_trap & ~i_mret;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      mie    <= 1'b0;
      mpie   <= 1'b0;
      mepc   <= 32'd0;
      mcause <= 32'd0;
      mtval  <= 32'd0;
    end else if (i_trap) begin
      mepc   <= i_trap_pc & LOW2_MASK;
      mcause <= i_trap_cause;
      mtval  <= i_trap_val;
      mpie   <= mie;
      mie    <= 1'b0;
    end else if (i_mret) begin
      mie  <= mpie;
      mpie <= 1'b1;
    end else if (sys_wr) begin
      case (i_addr)
        A_MSTATUS: begin
          mie  <= wr_val[3];
          mpie <= wr_val[7];
        end
        A_MEPC:   mepc   <= wr_val & LOW2_MASK;
        A_MCAUSE: mcause <= wr_val;
        A_MTVAL:  mtval  <= wr_val;
        default: ;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      mtvec    <= MTVEC_RESET & LOW2_MASK;
      mscratch <= 32'd0;
    end else if (do_write) begin
      if (i_addr == A_MTVEC)    mtvec    <= wr_val & LOW2_MASK;
      if (i_addr == A_MSCRATCH) mscratch <= wr_val;
    end
  end

  // A write to either half loads it and suppresses that counter's increment
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      mcycle   <= 64'd0;
      minstret <= 64'd0;
    end else if (COUNTER_EN) begin
      if (do_write && i_addr == A_MCYCLE)        mcycle <= {mcycle[63:32], wr_val};
      else if (do_write && i_addr == A_MCYCLEH)  mcycle <= {wr_val, mcycle[31:0]};
      else                                       mcycle <= mcycle + 64'd1;

      if (do_write && i_addr == A_MINSTRET)       minstret <= {minstret[63:32], wr_val};
      else if (do_write && i_addr == A_MINSTRETH) minstret <= {wr_val, minstret[31:0]};
      else if (i_retire)                          minstret <= minstret + 64'd1;
    end
  end

  assign o_trap_vector = {mtvec[31:2], 2'b00};
  assign o_epc         = mepc;
  assign o_mie         = mie;

endmodule

// File: tb/tb_csr_unit.sv
// Directed bench for csr_unit: expected values are queued as stimulus is applied
// and popped when the corresponding DUT output is sampled.
module tb_csr_unit;

  localparam logic [31:0] HART_ID     = 32'd5;
  localparam logic [31:0] MTVEC_RESET = 32'h8000_0103;

  logic        clk, rst_n;
  logic        rd, wr, set, clr, retire, trap, mret;
  logic [11:0] addr;
  logic [31:0] wr_data, trap_pc, trap_cause, trap_val;
  logic [31:0] rd_data, trap_vector, epc;
  logic        illegal, mie;

  int errors = 0;
  int checks = 0;
  logic [31:0] exp_q[$];

  csr_unit #(.HART_ID(HART_ID), .MTVEC_RESET(MTVEC_RESET), .COUNTER_EN(1'b1)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_rd(rd), .i_wr(wr), .i_set(set), .i_clr(clr),
    .i_addr(addr), .i_wr_data(wr_data), .o_rd_data(rd_data), .o_illegal(illegal),
    .i_retire(retire), .i_trap(trap), .i_trap_pc(trap_pc), .i_trap_cause(trap_cause),
    .i_trap_val(trap_val), .i_mret(mret), .o_trap_vector(trap_vector), .o_epc(epc),
    .o_mie(mie)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic push(input logic [31:0] v);
    exp_q.push_back(v);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs);
    logic [31:0] e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL %s: observed %h but scoreboard empty", tag, obs);
    end else begin
      e = exp_q.pop_front();
      assert (obs === e) else begin
        errors++;
        $error("FAIL %s: observed %h expected %h", tag, obs, e);
      end
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    rd = 0; wr = 0; set = 0; clr = 0; trap = 0; mret = 0; retire = 0;
    wr_data = 0;
  endtask

  task automatic read_chk(input logic [11:0] a, input logic [31:0] e, input string tag);
    idle();
    addr = a; rd = 1;
    push(e);
    #1;
    chk(tag, rd_data);
    rd = 0;
  endtask

  initial begin
    idle();
    addr = 12'h7C0; trap_pc = 0; trap_cause = 0; trap_val = 0;
    rst_n = 0;
    rd = 1;
    push(32'd1);            push(MTVEC_RESET & 32'hFFFF_FFFC);
    push(32'd0);            push(32'd0);
    #12;
    chk("rst_illegal", {31'd0, illegal});
    chk("rst_tvec", trap_vector);
    chk("rst_epc", epc);
    chk("rst_mie", {31'd0, mie});
    rd = 0;

    // release just after a rising edge; 10 edges later mcycle is exactly 10
    @(posedge clk); #1;
    rst_n = 1;
    repeat (10) cyc();
    read_chk(12'hB00, 32'd10, "mcycle_10");
    read_chk(12'hB80, 32'd0, "mcycleh_0");
    read_chk(12'hB02, 32'd0, "minstret_idle");

    cyc();
    retire = 1;
    repeat (3) cyc();
    retire = 0;
    read_chk(12'hB02, 32'd3, "minstret_3");
    read_chk(12'hC02, 32'd3, "instret_alias");

    // low-half carry into high half
    cyc();
    idle(); addr = 12'hB00; wr = 1; wr_data = 32'hFFFF_FFFF;
    cyc();
    idle();
    cyc();
    read_chk(12'hB80, 32'd1, "carry_hi");
    read_chk(12'hB00, 32'd0, "carry_lo");
    read_chk(12'hC80, 32'd1, "cycleh_alias");

    // 64-bit wrap
    idle(); addr = 12'hB80; wr = 1; wr_data = 32'hFFFF_FFFF;
    cyc();
    addr = 12'hB00; wr_data = 32'hFFFF_FFFE;
    cyc();
    idle();
    cyc();
    cyc();
    read_chk(12'hB00, 32'd0, "wrap_lo");
    read_chk(12'hB80, 32'd0, "wrap_hi");

    // illegal write to read-only counter alias leaves the count running
    idle(); addr = 12'hC00; wr = 1; wr_data = 32'h1234;
    push(32'd1); #1; chk("ro_wr_illegal", {31'd0, illegal});
    cyc();
    idle();
    read_chk(12'hB00, 32'd1, "ro_wr_no_load");

    idle(); addr = 12'hF14; set = 1; wr_data = 0;
    push(32'd0); push(HART_ID); #1;
    chk("hartid_set0_legal", {31'd0, illegal});
    chk("hartid_val", rd_data);
    wr_data = 32'd1;
    push(32'd1); #1; chk("hartid_set1_illegal", {31'd0, illegal});
    idle(); addr = 12'h7C0; rd = 1;
    push(32'd1); push(32'd0); #1;
    chk("unimpl_illegal", {31'd0, illegal});
    chk("unimpl_rd0", rd_data);
    idle(); addr = 12'h300; clr = 1; wr_data = 0;
    push(32'd0); #1; chk("clr0_legal", {31'd0, illegal});

    // trap / mret round trip
    idle(); addr = 12'h300; set = 1; wr_data = 32'h8;
    cyc();
    idle();
    push(32'd1); #1; chk("mie_set", {31'd0, mie});
    read_chk(12'h300, 32'h1808, "mstatus_set");
    trap = 1; trap_pc = 32'h1002; trap_cause = 32'hB; trap_val = 32'hDEAD;
    cyc();
    idle();
    push(32'd0); push(32'h1000); #1;
    chk("trap_mie", {31'd0, mie});
    chk("trap_epc_port", epc);
    read_chk(12'h300, 32'h1880, "trap_mstatus");
    read_chk(12'h341, 32'h1000, "trap_mepc");
    read_chk(12'h342, 32'hB, "trap_mcause");
    read_chk(12'h343, 32'hDEAD, "trap_mtval");
    mret = 1;
    cyc();
    idle();
    push(32'd1); #1; chk("mret_mie", {31'd0, mie});
    read_chk(12'h300, 32'h1888, "mret_mstatus");

    // same-cycle priorities
    idle(); trap = 1; trap_pc = 32'h2004; addr = 12'h341; wr = 1; wr_data = 32'h40;
    cyc();
    idle();
    read_chk(12'h341, 32'h2004, "trap_over_mepc_wr");
    trap = 1; trap_pc = 32'h3000; addr = 12'h340; wr = 1; wr_data = 32'h55;
    cyc();
    idle();
    read_chk(12'h340, 32'h55, "mscratch_with_trap");
    read_chk(12'h341, 32'h3000, "mepc_second_trap");

    idle(); addr = 12'h340; clr = 1; wr_data = 32'h05;
    cyc();
    idle();
    read_chk(12'h340, 32'h50, "mscratch_clr");
    addr = 12'h305; wr = 1; wr_data = 32'h1234_5677;
    cyc();
    idle();
    read_chk(12'h305, 32'h1234_5674, "mtvec_mask");
    push(32'h1234_5674); #1; chk("tvec_port", trap_vector);

    // reset arriving mid-trap discards the trap
    trap = 1; trap_pc = 32'h4000; trap_cause = 32'h7;
    #1 rst_n = 0;
    push(32'd0); push(MTVEC_RESET & 32'hFFFF_FFFC); #1;
    chk("rst_midtrap_epc", epc);
    chk("rst_midtrap_tvec", trap_vector);
    cyc();
    idle();
    rst_n = 1;
    push(32'd0); #1; chk("rst_release_epc", epc);
    read_chk(12'h342, 32'd0, "rst_mcause");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
